// File: rtl/flag_c_update_sequencer.sv
// Carry-flag (F_C) update sequencer: buffers decoder ops in a small FIFO and issues each one as a
// single registered cycle of one-hot source select / write / exchange / restore controls.
module flag_c_update_sequencer #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned EX_GUARD   = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            cmd_valid,
  input  logic [OP_W-1:0] cmd_op,
  output logic            cmd_ready,
  output logic            PF_Write_C,
  output logic            PF_Select_C_bit17,
  output logic            notPF_Select_C_bit23,
  output logic            notPF_Select_C_bit26,
  output logic            notPF_Select_C_bit29,
  output logic            notPF_Select_C_bit32,
  output logic            notPF_Select_C_bit36,
  output logic            notPF_Select_C_bit37,
  output logic            notPF_Select_C_bit38,
  output logic            PF_Select_C_bit0,
  output logic            PR_Ex,
  output logic            notPR_Ex,
  output logic            PR_Write,
  output logic            busy,
  output logic            done,
  output logic            err_illegal
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [1:0]  GuardInit = 2'(EX_GUARD - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StGuard} state_e;

  state_e            r_state, w_state_d;
  logic [1:0]        r_guard, w_guard_d;
  logic [OP_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;
  logic              r_ready;

  // r_sel one-hot index: 0=bit17 1=bit23 2=bit26 3=bit29 4=bit32 5=bit36 6=bit37 7=bit38
  logic [7:0]        r_sel;
  logic              r_write_c, r_sel_b0, r_pr_ex, r_pr_write, r_done, r_err;

  logic              w_push, w_pop, w_empty, w_full;
  logic [OP_W-1:0]   w_head;
  logic [7:0]        w_d_sel;
  logic              w_d_write, w_d_b0, w_d_ex, w_d_prw, w_d_done, w_d_err;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntW'(FIFO_DEPTH));
  assign cmd_ready = r_ready & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_head    = r_mem[r_rptr];

  always_comb begin
    w_d_sel   = '0;
    w_d_write = 1'b0;
    w_d_b0    = 1'b0;
    w_d_ex    = 1'b0;
    w_d_prw   = 1'b0;
    w_d_done  = 1'b0;
    w_d_err   = 1'b0;
    if (w_head >= OP_W'(1) && w_head <= OP_W'(8)) begin
      w_d_write = 1'b1;
      w_d_sel   = 8'(1) << (w_head - OP_W'(1));
      w_d_done  = 1'b1;
    end else if (w_head == OP_W'(0)) begin
      w_d_done = 1'b1;
    end else if (w_head == OP_W'(9)) begin
      w_d_ex   = 1'b1;
      w_d_done = 1'b1;
    end else if (w_head == OP_W'(10)) begin
      w_d_b0   = 1'b1;
      w_d_prw  = 1'b1;
      w_d_done = 1'b1;
    end else begin
      w_d_err = 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_guard_d = r_guard;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        // r_pr_ex high means the op being issued right now is an exchange
        if (r_pr_ex && EX_GUARD != 0) begin
          w_state_d = StGuard;
          w_guard_d = GuardInit;
        end else if (!w_empty) begin
          w_pop = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      StGuard: begin
        if (r_guard == 2'd0) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_d = StIssue;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_guard_d = r_guard - 2'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wptr] <= cmd_op;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_guard    <= 2'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_sel      <= '0;
      r_write_c  <= 1'b0;
      r_sel_b0   <= 1'b0;
      r_pr_ex    <= 1'b0;
      r_pr_write <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_guard    <= w_guard_d;
      r_ready    <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_sel      <= w_pop ? w_d_sel : '0;
      r_write_c  <= w_pop & w_d_write;
      r_sel_b0   <= w_pop & w_d_b0;
      r_pr_ex    <= w_pop & w_d_ex;
      r_pr_write <= w_pop & w_d_prw;
      r_done     <= w_pop & w_d_done;
      r_err      <= w_pop & w_d_err;
    end
  end

  assign PF_Write_C           = r_write_c;
  assign PF_Select_C_bit17    = r_sel[0];
  assign notPF_Select_C_bit23 = ~r_sel[1];
  assign notPF_Select_C_bit26 = ~r_sel[2];
  assign notPF_Select_C_bit29 = ~r_sel[3];
  assign notPF_Select_C_bit32 = ~r_sel[4];
  assign notPF_Select_C_bit36 = ~r_sel[5];
  assign notPF_Select_C_bit37 = ~r_sel[6];
  assign notPF_Select_C_bit38 = ~r_sel[7];
  assign PF_Select_C_bit0     = r_sel_b0;
  assign PR_Ex                = r_pr_ex;
  assign notPR_Ex             = ~r_pr_ex;
  assign PR_Write             = r_pr_write;
  assign done                 = r_done;
  assign err_illegal          = r_err;
  assign busy                 = ~w_empty | (r_state != StIdle);

endmodule

// File: tb/tb_flag_c_update_sequencer.sv
// Directed bench for flag_c_update_sequencer: scripted op pushes, cycle-by-cycle control checks.
module tb_flag_c_update_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_op = 4'd0;
  logic       cmd_ready, PF_Write_C, PF_Select_C_bit17;
  logic       notPF_Select_C_bit23, notPF_Select_C_bit26, notPF_Select_C_bit29;
  logic       notPF_Select_C_bit32, notPF_Select_C_bit36, notPF_Select_C_bit37;
  logic       notPF_Select_C_bit38, PF_Select_C_bit0, PR_Ex, notPR_Ex, PR_Write;
  logic       busy, done, err_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  flag_c_update_sequencer #(
    .FIFO_DEPTH(2),
    .OP_W      (4),
    .EX_GUARD  (1)
  ) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .cmd_valid           (cmd_valid),
    .cmd_op              (cmd_op),
    .cmd_ready           (cmd_ready),
    .PF_Write_C          (PF_Write_C),
    .PF_Select_C_bit17   (PF_Select_C_bit17),
    .notPF_Select_C_bit23(notPF_Select_C_bit23),
    .notPF_Select_C_bit26(notPF_Select_C_bit26),
    .notPF_Select_C_bit29(notPF_Select_C_bit29),
    .notPF_Select_C_bit32(notPF_Select_C_bit32),
    .notPF_Select_C_bit36(notPF_Select_C_bit36),
    .notPF_Select_C_bit37(notPF_Select_C_bit37),
    .notPF_Select_C_bit38(notPF_Select_C_bit38),
    .PF_Select_C_bit0    (PF_Select_C_bit0),
    .PR_Ex               (PR_Ex),
    .notPR_Ex            (notPR_Ex),
    .PR_Write            (PR_Write),
    .busy                (busy),
    .done                (done),
    .err_illegal         (err_illegal)
  );

  // {W, s17, n23, n26, n29, n32, n36, n37, n38, b0, Ex, nEx, PRW, done, err}
  logic [14:0] w_ctl;
  assign w_ctl = {PF_Write_C, PF_Select_C_bit17, notPF_Select_C_bit23, notPF_Select_C_bit26,
                  notPF_Select_C_bit29, notPF_Select_C_bit32, notPF_Select_C_bit36,
                  notPF_Select_C_bit37, notPF_Select_C_bit38, PF_Select_C_bit0, PR_Ex,
                  notPR_Ex, PR_Write, done, err_illegal};

  localparam logic [14:0] CtlIdle = 15'b0_0_1111111_0_0_1_0_0_0;
  localparam logic [14:0] CtlOp1  = 15'b1_1_1111111_0_0_1_0_1_0;
  localparam logic [14:0] CtlOp2  = 15'b1_0_0111111_0_0_1_0_1_0;
  localparam logic [14:0] CtlOp3  = 15'b1_0_1011111_0_0_1_0_1_0;
  localparam logic [14:0] CtlOp4  = 15'b1_0_1101111_0_0_1_0_1_0;
  localparam logic [14:0] CtlOp5  = 15'b1_0_1110111_0_0_1_0_1_0;
  localparam logic [14:0] CtlOp7  = 15'b1_0_1111101_0_0_1_0_1_0;
  localparam logic [14:0] CtlOp9  = 15'b0_0_1111111_0_1_0_0_1_0;
  localparam logic [14:0] CtlOp10 = 15'b0_0_1111111_1_0_1_1_1_0;
  localparam logic [14:0] CtlIll  = 15'b0_0_1111111_0_0_1_0_0_1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op);
    cmd_valid = v;
    cmd_op    = op;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check_eq("rst_ctl", 32'(w_ctl), 32'(CtlIdle));
    check_eq("rst_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    #1;
    check_eq("ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();
    check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 1: SET latency
    drive(1'b1, 4'd1);
    tick();
    drive(1'b0, 4'd0);
    check_eq("t1_c0_ctl", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t1_c0_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t1_c1_ctl", 32'(w_ctl), 32'(CtlOp1));
    tick();
    check_eq("t1_c2_ctl", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t1_c2_busy", 32'(busy), 32'd0);

    // 2: back-to-back 2,5,7
    drive(1'b1, 4'd2);
    tick();
    check_eq("t2_c0_ctl", 32'(w_ctl), 32'(CtlIdle));
    drive(1'b1, 4'd5);
    tick();
    check_eq("t2_op2", 32'(w_ctl), 32'(CtlOp2));
    drive(1'b1, 4'd7);
    tick();
    check_eq("t2_op5", 32'(w_ctl), 32'(CtlOp5));
    drive(1'b0, 4'd0);
    tick();
    check_eq("t2_op7", 32'(w_ctl), 32'(CtlOp7));
    tick();
    check_eq("t2_end", 32'(w_ctl), 32'(CtlIdle));

    // 3: EXX then nCY8 with one guard cycle
    drive(1'b1, 4'd9);
    tick();
    drive(1'b1, 4'd3);
    tick();
    drive(1'b0, 4'd0);
    check_eq("t3_exx", 32'(w_ctl), 32'(CtlOp9));
    tick();
    check_eq("t3_guard", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t3_guard_busy", 32'(busy), 32'd1);
    tick();
    check_eq("t3_op3", 32'(w_ctl), 32'(CtlOp3));
    tick();
    check_eq("t3_end", 32'(w_ctl), 32'(CtlIdle));

    // 4: POP
    drive(1'b1, 4'd10);
    tick();
    drive(1'b0, 4'd0);
    tick();
    check_eq("t4_pop", 32'(w_ctl), 32'(CtlOp10));
    tick();
    check_eq("t4_end", 32'(w_ctl), 32'(CtlIdle));

    // 5: guard stall fills the 2-deep FIFO; ops 1..4 must come out in order
    drive(1'b1, 4'd9);
    tick();
    drive(1'b1, 4'd1);
    tick();
    check_eq("t5_exx", 32'(w_ctl), 32'(CtlOp9));
    check_eq("t5_ready_c1", 32'(cmd_ready), 32'd1);
    drive(1'b1, 4'd2);
    tick();
    check_eq("t5_guard", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t5_full_ready", 32'(cmd_ready), 32'd0);
    drive(1'b1, 4'd3);
    tick();
    check_eq("t5_op1", 32'(w_ctl), 32'(CtlOp1));
    check_eq("t5_ready_c3", 32'(cmd_ready), 32'd1);
    tick();
    check_eq("t5_op2", 32'(w_ctl), 32'(CtlOp2));
    drive(1'b1, 4'd4);
    tick();
    drive(1'b0, 4'd0);
    check_eq("t5_op3", 32'(w_ctl), 32'(CtlOp3));
    tick();
    check_eq("t5_op4", 32'(w_ctl), 32'(CtlOp4));
    tick();
    check_eq("t5_end", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t5_end_busy", 32'(busy), 32'd0);

    // 6: illegal op, then async reset during its issue with another op still queued
    drive(1'b1, 4'd12);
    tick();
    drive(1'b1, 4'd5);
    tick();
    drive(1'b0, 4'd0);
    check_eq("t6_illegal", 32'(w_ctl), 32'(CtlIll));
    check_eq("t6_busy", 32'(busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("t6_async_ctl", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t6_async_ready", 32'(cmd_ready), 32'd0);
    check_eq("t6_async_busy", 32'(busy), 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check_eq("t6_rel_ready", 32'(cmd_ready), 32'd1);
    check_eq("t6_rel_busy", 32'(busy), 32'd0);
    tick();
    check_eq("t6_discard_ctl", 32'(w_ctl), 32'(CtlIdle));
    check_eq("t6_discard_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
